z16_fetch_unit: RTL and testbench

Instruction-fetch sequencer for the Z16 core. It owns the fetch PC and drives the address input of the combinational, byte-addressed instruction memory (16-bit instructions at even addresses). It buffers fetched {pc, instr} pairs in a small prefetch queue and hands them to decode with a valid/ready handshake. A branch/jump redirect from execute flushes the queue.

---
 rtl/z16_defs.sv | 16 +
 rtl/z16_fetch_queue.sv | 47 ++++
 rtl/z16_fetch_unit.sv | 93 +++++++++
 tb/tb_z16_fetch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/z16_defs.sv
// Shared Z16 constants, fetch FSM encodings and the prefetch entry layout.
package z16_defs;
  localparam int Z16_XLEN        = 16;
  localparam int Z16_INSTR_BYTES = 2;
  localparam logic [Z16_XLEN-1:0] Z16_NOP = 16'h0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [Z16_XLEN-1:0] pc;
    logic [Z16_XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/z16_fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs; flush clears it in one cycle.
module z16_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 fetch sequencer: owns the fetch PC, fills the prefetch queue, handles redirects.
// Optional performance counters are enabled with the Z16_FETCH_PERF_EN macro.
module z16_fetch_unit
  import z16_defs::*;
#(
  parameter logic [Z16_XLEN-1:0] RESET_PC = 16'h0000,
  parameter int                  DEPTH    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [Z16_XLEN-1:0] o_imem_addr,
  input  logic [Z16_XLEN-1:0] i_imem_instr,
  input  logic                i_redirect,
  input  logic [Z16_XLEN-1:0] i_redirect_addr,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [Z16_XLEN-1:0] o_instr,
  output logic [Z16_XLEN-1:0] o_instr_pc
`ifdef Z16_FETCH_PERF_EN
  ,
  output logic [15:0]         o_stall_cnt,
  output logic [15:0]         o_flush_cnt
`endif
);
  logic [Z16_XLEN-1:0]    pc;
  fetch_state_t           state;
  logic                   push;
  logic                   pop;
  logic [31:0]            q_rdata;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;
  fetch_entry_t           head;

  // A full queue still accepts a new entry when the head leaves this cycle.
  assign pop  = o_valid & i_ready;
  assign push = !i_redirect & (!q_full | pop);

  z16_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_queue (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({pc, i_imem_instr}),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb assert (q_empty == (q_count == '0));

  assign head        = fetch_entry_t'(q_rdata);
  assign o_valid     = !q_empty;
  assign o_instr     = o_valid ? head.instr : Z16_NOP;
  assign o_instr_pc  = o_valid ? head.pc    : Z16_NOP;
  assign o_imem_addr = pc;

  always_ff @(posedge i_clk) begin
    if (i_rst)           pc <= RESET_PC;
    else if (i_redirect) pc <= {i_redirect_addr[Z16_XLEN-1:1], 1'b0};
    else if (push)       pc <= pc + Z16_XLEN'(Z16_INSTR_BYTES);
  end

  // FLUSH marks the bubble cycle right after a redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= i_redirect ? FLUSH : RUN;
        FLUSH:   state <= i_redirect ? FLUSH : RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef Z16_FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
      if (i_redirect && o_flush_cnt != 16'hFFFF)          o_flush_cnt <= o_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_z16_fetch_unit.sv
// Directed bench for z16_fetch_unit (DEPTH=4, RESET_PC=0); memory returns addr^A5A5.
module tb_z16_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        valid;
  logic        ready = 1'b1;
  logic [15:0] instr;
  logic [15:0] instr_pc;
`ifdef Z16_FETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ 16'hA5A5;

  z16_fetch_unit #(
    .RESET_PC (16'h0000),
    .DEPTH    (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_imem_addr     (imem_addr),
    .i_imem_instr    (imem_instr),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc)
`ifdef Z16_FETCH_PERF_EN
    ,
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [15:0] raddr;
    logic        chk;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic rdy, input logic rd, input logic [15:0] ra,
                         input logic c, input logic v, input logic [15:0] p, input logic [15:0] a);
    vec_t t;
    t.rst = r; t.ready = rdy; t.redir = rd; t.raddr = ra;
    t.chk = c; t.valid = v; t.pc = p; t.addr = a;
    vecs.push_back(t);
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst           = v.rst;
    ready         = v.ready;
    redirect      = v.redir;
    redirect_addr = v.raddr;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] p, input logic [15:0] a);
    logic [15:0] exp_instr;
    exp_instr = v ? (p ^ 16'hA5A5) : 16'h0000;
    check_output({tag, " valid"}, 16'(valid), 16'(v));
    check_output({tag, " pc"}, instr_pc, v ? p : 16'h0000);
    check_output({tag, " instr"}, instr, exp_instr);
    check_output({tag, " addr"}, imem_addr, a);
  endtask

  initial begin
    int cyc;
    //      rst  rdy  redir raddr     chk  valid pc       addr
    add_vec(1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000); // v0
    add_vec(1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000); // v1 reset state
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000); // v2 first push
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0000,16'h0002);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0002,16'h0004);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0004,16'h0006);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h0008); // v6 stall begins
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000A);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000C);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000E); // v9 full
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000E);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000E);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000E);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0006,16'h000E); // v13 full + pop
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0008,16'h0010);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h000A,16'h0012);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h000C,16'h0014);
    add_vec(1'b0,1'b0,1'b1,16'h0123, 1'b1,1'b1,16'h000E,16'h0016); // v17 redirect when full
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h0122);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0122,16'h0124);
    add_vec(1'b0,1'b1,1'b1,16'hFFFE, 1'b1,1'b1,16'h0124,16'h0126); // v20 redirect to FFFE
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'hFFFE);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'hFFFE,16'h0000);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0000,16'h0002);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0002,16'h0004);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0004,16'h0006); // v25 refill
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0004,16'h0008);
    add_vec(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0004,16'h000A);
    add_vec(1'b1,1'b0,1'b1,16'h0456, 1'b1,1'b1,16'h0004,16'h000C); // v28 reset beats redirect
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0000,16'h0002);
    add_vec(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0002,16'h0004);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      if (vecs[i].chk) check_head($sformatf("v%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].addr);
    end

    // Odd redirect target: bit 0 dropped, head appears two cycles later.
    @(negedge clk);
    redirect      = 1'b1;
    redirect_addr = 16'h0201;
    ready         = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_output("redir addr", imem_addr, 16'h0200);
    cyc = 1;
    while (!valid && cyc < 8) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_output("redir latency", 16'(cyc), 16'd2);
    check_output("redir head pc", instr_pc, 16'h0200);
    check_output("redir head instr", instr, 16'h0200 ^ 16'hA5A5);

`ifdef Z16_FETCH_PERF_EN
    check_output("flush cnt 1", flush_cnt, 16'd1);
    check_output("stall cnt 0", stall_cnt, 16'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ready = 1'b0;
    end
    @(negedge clk);
    ready         = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'h0300;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_output("stall cnt 5", stall_cnt, 16'd5);
    check_output("flush cnt 2", flush_cnt, 16'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
